// File: rtl/pcm_feeder.sv
// rtl/pcm_feeder.sv - MMIO packed-PCM unpacker feeding the PWM sample FIFO
module pcm_feeder (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [3:0]  addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    input  logic        fifo_full,
    output logic        pcm_we,
    output logic [7:0]  pcm_o
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PUSH = 1'b1;

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_CTRL = 2'd1;
    localparam logic [1:0] A_STAT = 2'd2;

    logic [0:0]  state;
    logic [4:0]  ctrl;
    logic [15:0] word_cnt;
    logic [31:0] sample_buf;
    logic [2:0]  remaining;
    logic        mode_q;
    logic [2:0]  att_q;

    logic        req;
    logic        is_write;
    logic        data_wr;
    logic        accept;
    logic [31:0] rd_val;
    logic [7:0]  u;
    logic signed [8:0] s;
    logic signed [8:0] s_att;

    always_comb begin
        req      = valid & ~ready;
        is_write = |wstrb;
        data_wr  = req & is_write & (addr[3:2] == A_DATA);
        // Only DATA writes stall while a word drains; everything else acks next cycle.
        accept   = req & ~(data_wr & (state == PUSH));

        rd_val = 32'h0;
        case (addr[3:2])
            A_CTRL:  rd_val = {27'h0, ctrl};
            A_STAT:  rd_val = {word_cnt, 14'h0, (state == PUSH), fifo_full};
            default: rd_val = 32'h0;
        endcase

        u      = mode_q ? (sample_buf[15:8] ^ 8'h80) : sample_buf[7:0];
        // u - 128 as 9-bit signed is just the flipped MSB, sign-extended.
        s      = {~u[7], ~u[7], u[6:0]};
        s_att  = s >>> att_q;
        pcm_o  = s_att[7:0] ^ 8'h80;
        pcm_we = (state == PUSH) & ~fifo_full;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ctrl       <= 5'h02;
            word_cnt   <= 16'h0;
            sample_buf <= 32'h0;
            remaining  <= 3'd0;
            mode_q     <= 1'b0;
            att_q      <= 3'd0;
            ready      <= 1'b0;
            rdata      <= 32'h0;
        end else begin
            ready <= accept;
            rdata <= (accept && !is_write) ? rd_val : 32'h0;

            if (accept && is_write && (addr[3:2] == A_CTRL))
                ctrl <= wdata[4:0];

            if (accept && data_wr && ctrl[1]) begin
                sample_buf <= wdata;
                mode_q     <= ctrl[0];
                att_q      <= ctrl[4:2];
                remaining  <= ctrl[0] ? 3'd2 : 3'd4;
                state      <= PUSH;
                word_cnt   <= word_cnt + 16'd1;
            end else if (pcm_we) begin
                sample_buf <= mode_q ? (sample_buf >> 16) : (sample_buf >> 8);
                remaining  <= remaining - 3'd1;
                if (remaining == 3'd1)
                    state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_pcm_feeder.sv
// tb/tb_pcm_feeder.sv - directed self-checking bench for pcm_feeder
module tb_pcm_feeder;
    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [3:0]  addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        fifo_full;
    logic        pcm_we;
    logic [7:0]  pcm_o;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int full_viol = 0;
    int ready_cyc = 0;
    logic [7:0] pushq[$];
    int         pushc[$];

    pcm_feeder dut (
        .clk(clk), .reset(reset), .valid(valid), .addr(addr), .wstrb(wstrb),
        .wdata(wdata), .rdata(rdata), .ready(ready), .fifo_full(fifo_full),
        .pcm_we(pcm_we), .pcm_o(pcm_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset && pcm_we) begin
            pushq.push_back(pcm_o);
            pushc.push_back(cyc);
            if (fifo_full) full_viol++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] q_at(input int i);
        if (i < pushq.size()) return pushq[i];
        return 8'hxx;
    endfunction

    function automatic int c_at(input int i);
        if (i < pushc.size()) return pushc[i];
        return -1000;
    endfunction

    task automatic clear_mon();
        pushq.delete();
        pushc.delete();
    endtask

    task automatic bus(input logic [3:0] a, input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] r);
        int n;
        @(posedge clk); #1;
        valid = 1'b1; addr = a; wstrb = s; wdata = d;
        n = 0;
        @(negedge clk);
        while (!ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("bus_ack", {31'h0, ready}, 32'h1);
        r = rdata;
        ready_cyc = cyc;
        @(posedge clk); #1;
        valid = 1'b0; wstrb = 4'h0;
        check("ready_single_cycle", {31'h0, ready}, 32'h0);
    endtask

    typedef struct {
        logic [3:0]  a;
        logic [3:0]  s;
        logic [31:0] d;
        logic        chk;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    vec_t vt[10];
    logic [31:0] r;
    int n;
    int r2;

    initial begin
        reset = 1'b1; valid = 1'b0; fifo_full = 1'b0;
        addr = 4'h0; wstrb = 4'h0; wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_ready", {31'h0, ready}, 32'h0);
        check("rst_pcm_we", {31'h0, pcm_we}, 32'h0);
        check("rst_pcm_o", {24'h0, pcm_o}, 32'h0);
        check("rst_rdata", rdata, 32'h0);

        vt[0] = '{4'h4, 4'h0, 32'h0,        1'b1, 32'h2,  "ctrl_reset"};
        vt[1] = '{4'h8, 4'h0, 32'h0,        1'b1, 32'h0,  "status_reset"};
        vt[2] = '{4'h0, 4'h0, 32'h0,        1'b1, 32'h0,  "data_reads_zero"};
        vt[3] = '{4'hC, 4'h0, 32'h0,        1'b1, 32'h0,  "unmapped_read"};
        vt[4] = '{4'hC, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0,  "unmapped_write"};
        vt[5] = '{4'h4, 4'h0, 32'h0,        1'b1, 32'h2,  "ctrl_after_unmapped"};
        vt[6] = '{4'h4, 4'h1, 32'hFFFFFFFD, 1'b0, 32'h0,  "ctrl_write"};
        vt[7] = '{4'h5, 4'h0, 32'h0,        1'b1, 32'h1D, "ctrl_field_mask"};
        vt[8] = '{4'h4, 4'h8, 32'h00000002, 1'b0, 32'h0,  "ctrl_restore"};
        vt[9] = '{4'h4, 4'h0, 32'h0,        1'b1, 32'h2,  "ctrl_restored"};
        for (int i = 0; i < 10; i++) begin
            bus(vt[i].a, vt[i].s, vt[i].d, r);
            if (vt[i].chk) check(vt[i].nm, r, vt[i].exp);
        end

        // u8 unpack
        clear_mon();
        bus(4'h0, 4'hF, 32'h44332211, r);
        repeat (10) @(posedge clk);
        check("u8_count", pushq.size(), 4);
        check("u8_s0", {24'h0, q_at(0)}, 32'h11);
        check("u8_s1", {24'h0, q_at(1)}, 32'h22);
        check("u8_s2", {24'h0, q_at(2)}, 32'h33);
        check("u8_s3", {24'h0, q_at(3)}, 32'h44);
        check("u8_consecutive", c_at(3) - c_at(0), 3);
        bus(4'h8, 4'h0, 32'h0, r);
        check("u8_status", r, 32'h00010000);

        // s16 unpack
        bus(4'h4, 4'hF, 32'h3, r);
        clear_mon();
        bus(4'h0, 4'hF, 32'h7FFF8000, r);
        repeat (10) @(posedge clk);
        check("s16_count", pushq.size(), 2);
        check("s16_s0", {24'h0, q_at(0)}, 32'h00);
        check("s16_s1", {24'h0, q_at(1)}, 32'hFF);
        check("s16_consecutive", c_at(1) - c_at(0), 1);

        // backpressure after the first push
        bus(4'h4, 4'hF, 32'h2, r);
        clear_mon();
        @(posedge clk); #1;
        valid = 1'b1; addr = 4'h0; wstrb = 4'hF; wdata = 32'hDDCCBBAA;
        n = 0;
        @(negedge clk);
        while (!pcm_we && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("bp_first_push_seen", {31'h0, pcm_we}, 32'h1);
        @(posedge clk); #1;
        fifo_full = 1'b1; valid = 1'b0; wstrb = 4'h0;
        repeat (3) @(posedge clk);
        #1 fifo_full = 1'b0;
        repeat (10) @(posedge clk);
        check("bp_count", pushq.size(), 4);
        check("bp_s0", {24'h0, q_at(0)}, 32'hAA);
        check("bp_s1", {24'h0, q_at(1)}, 32'hBB);
        check("bp_s2", {24'h0, q_at(2)}, 32'hCC);
        check("bp_s3", {24'h0, q_at(3)}, 32'hDD);
        check("bp_gap", c_at(1) - c_at(0), 4);
        check("bp_resume", c_at(3) - c_at(1), 2);
        check("bp_no_push_while_full", full_viol, 0);

        // attenuation
        bus(4'h4, 4'hF, 32'h6, r);
        clear_mon();
        bus(4'h0, 4'hF, 32'h008000FF, r);
        repeat (10) @(posedge clk);
        check("att_count", pushq.size(), 4);
        check("att_s0", {24'h0, q_at(0)}, 32'hBF);
        check("att_s1", {24'h0, q_at(1)}, 32'h40);
        check("att_s2", {24'h0, q_at(2)}, 32'h80);
        check("att_s3", {24'h0, q_at(3)}, 32'h40);

        // reset while a word is stalled in PUSH
        bus(4'h4, 4'hF, 32'h2, r);
        clear_mon();
        @(posedge clk); #1 fifo_full = 1'b1;
        bus(4'h0, 4'hF, 32'h12345678, r);
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0; fifo_full = 1'b0;
        repeat (10) @(posedge clk);
        check("rst_midpush_no_push", pushq.size(), 0);
        check("rst_midpush_pcm_o", {24'h0, pcm_o}, 32'h0);

        // back-to-back stall and counter
        clear_mon();
        bus(4'h0, 4'hF, 32'h04030201, r);
        bus(4'h0, 4'hF, 32'h08070605, r);
        r2 = ready_cyc;
        repeat (10) @(posedge clk);
        check("b2b_count", pushq.size(), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("b2b_s%0d", i), {24'h0, q_at(i)}, i + 1);
        check("b2b_ready_delay", r2 - c_at(3), 2);
        bus(4'h8, 4'h0, 32'h0, r);
        check("b2b_counter", r, 32'h00020000);

        // disabled DATA write
        bus(4'h4, 4'hF, 32'h0, r);
        clear_mon();
        bus(4'h0, 4'hF, 32'hAABBCCDD, r);
        repeat (8) @(posedge clk);
        check("dis_no_push", pushq.size(), 0);
        bus(4'h8, 4'h0, 32'h0, r);
        check("dis_counter", r, 32'h00020000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pcm_feeder.md
# pcm_feeder

MMIO audio sample front-end that sits directly upstream of the PWM audio DAC. Accepts 32-bit CPU bus writes of packed PCM, unpacks them into 8-bit unsigned samples, applies optional attenuation, and pushes one sample per cycle into the PWM sample FIFO. Stalls the bus while a word is still draining, and pauses on downstream `fifo_full`, so no sample is ever dropped.

## Interface
- No parameters; register map is fixed.
- clk  in  1  system clock (SYSTEM_CLK domain, same as PWM).
- reset  in  1  synchronous, active-high reset.
- valid  in  1  bus request; held by master until `ready`.
- addr  in  4  byte offset: 0x0 DATA, 0x4 CTRL, 0x8 STATUS; `addr[1:0]` ignored.
- wstrb  in  4  nonzero = write, zero = read.
- wdata  in  32  write data.
- rdata  out  32  read data, valid while `ready`=1.
- ready  out  1  registered single-cycle acknowledge.
- fifo_full  in  1  from PWM FIFO; no push is issued while high.
- pcm_we  out  1  push strobe to PWM `we`.
- pcm_o  out  8  unsigned sample to PWM `pcm_i`.

## Operation
- CTRL (RW) has three fields. Bit0 MODE selects the packing: 0 = 4× u8, 1 = 2× s16. Bit1 EN: when 0, DATA writes are acknowledged and discarded. Bits[4:2] ATT is an attenuation shift, 0..7. Other bits read 0. Reset value is 0x2.
- STATUS (RO) fields:
  - bit0 = `fifo_full`.
  - bit1 = busy (state PUSH).
  - bits[31:16] = accepted-word counter, 16-bit, wraps 0xFFFF→0. Counts only words latched with EN=1.
- DATA (WO) reads 0. Any nonzero `wstrb` writes the whole word.
- Unmapped offsets: reads return 0, writes are ignored, and `ready` is still given.
- The FSM has two states, IDLE and PUSH.
  - IDLE: a DATA write with EN=1 latches the word and snapshots MODE and ATT. It sets remaining = 4 (u8) or 2 (s16), then goes to PUSH.
  - PUSH: each cycle with `fifo_full`=0 drives `pcm_we`=1 with the current sample, shifts the buffer and decrements remaining. After the last push it returns to IDLE.
  - PUSH: a cycle with `fifo_full`=1 drives `pcm_we`=0 and holds state.
- Sample order is lowest byte/halfword first.
- Conversion in u8 mode: u = byte.
- Conversion in s16 mode: u = h[15:8] ^ 0x80 (offset binary; low byte discarded).
- Attenuation: s = u − 128 as 9-bit signed; s' = s >>> ATT (arithmetic); out = s' + 128, truncated to 8 bits. ATT=0 is the identity.
- CTRL writes during PUSH take effect for the next word only.

## Timing
- Reset values:
  - state IDLE, CTRL 0x2, counter 0.
  - `ready`=0, `pcm_we`=0, `pcm_o`=0, `rdata`=0.
- Reset mid-PUSH discards the remaining samples; no further `pcm_we` is issued.
- Non-DATA access: `valid` seen at cycle N gives `ready`=1 at N+1 for exactly one cycle. `rdata` is valid at N+1.
- CTRL write lands at N+1 (the `ready` cycle).
- DATA write in IDLE: `ready` at N+1, state PUSH at N+1, first `pcm_we` possible at N+1.
- DATA write in PUSH: `ready` stays low until the cycle after state returns to IDLE. It is then accepted as above.
- `ready` deasserts the cycle after it is seen, even if `valid` stays high. A new access needs `valid` observed again after that gap cycle.
- Throughput, unstalled:
  - u8: 4 samples in 4 consecutive cycles.
  - s16: 2 samples in 2 consecutive cycles.
  - Back-to-back words incur at least 2 cycles of bus turnaround between words.
- `pcm_we` = (state==PUSH) & ~`fifo_full`, combinational from the registered `fifo_full`. `pcm_o` is registered/muxed from the buffer and valid whenever `pcm_we`=1.
- When DATA is written with EN=0, `ready` is given and the state stays IDLE.

## Test plan
- Reset: assert `reset` 2 cycles → `ready`=0, `pcm_we`=0, `pcm_o`=0x00; CTRL reads 0x00000002; STATUS reads 0x00000000.
- u8 unpack: DATA=0x44332211, `fifo_full`=0 → `pcm_we` high 4 consecutive cycles with `pcm_o` 0x11, 0x22, 0x33, 0x44; STATUS[31:16]=1; busy clears afterward.
- s16 unpack: CTRL=0x3, DATA=0x7FFF8000 → 2 pushes, 0x00 then 0xFF.
- Backpressure: u8 DATA=0xDDCCBBAA, `fifo_full` high for 3 cycles after the first push → `pcm_we` low those 3 cycles; the sequence is still AA, BB, CC, DD with none lost or duplicated.
- Attenuation: CTRL=0x6 (ATT=1, EN, u8), DATA=0x008000FF → 0xBF, 0x40, 0x80, 0x40.
- Stall, counter and disable:
  - Two back-to-back DATA writes → the second `ready` is delayed until after the 4th push of the first word; 8 pushes total in order; counter=2.
  - Then CTRL=0x0 and a DATA write → `ready` pulses, no `pcm_we`, counter stays 2.
